hdmi_packet_assembler: RTL
==========================

Name: hdmi_packet_assembler

Overview:
- Sits directly downstream of the HDMI packet picker, in the clk_pixel domain.
- Drives the 5-bit per-packet pixel counter and the packet_enable strobe that the picker consumes.
- Serializes the picker's selected 24-bit header and four 56-bit subpackets into 32 cycles of 9-bit data-island symbol payload.
- Generates BCH ECC parity bytes on the fly and inserts them; the output feeds the TERC4 encoders of channels 0-2.

Parameters:
ECC_POLY  8'h83  reflected BCH generator 1+x^6+x^7+x^8, applied LSB-first

Ports:
clk_pixel  input  1  pixel clock
reset  input  1  synchronous, active-high reset
data_island_period  input  1  high for every data-island pixel; a multiple of 32 cycles per island
header  input  24  packet header from the picker; stable over each 32-cycle packet
sub  input  4x56  subpackets 0..3 from the picker; stable over each packet
packet_pixel_counter  output  5  position within the current packet, fed back to the picker
packet_enable  output  1  strobe: picker loads the next packet
packet_data  output  9  {odd bits sub3..0, even bits sub3..0, header bit}
packet_data_valid  output  1  packet_data corresponds to a data-island pixel

Behaviour:
- Reset applies on the clk_pixel edge with reset=1. Reset values: counter 0, all ECC registers 0, packet_data 0, packet_data_valid 0. A mid-packet reset abandons that packet; no partial parity is retained.
- Counter:
  - data_island_period=1: counter <= counter+1, wrapping 31->0.
  - data_island_period=0: counter <= 0.
- packet_enable = data_island_period && counter==31. This is combinational, so the picker's new header/sub are presented from the following counter==0 cycle.
- Pipeline latency is 1 cycle. packet_data and packet_data_valid are registered: the value at edge t+1 reflects counter c and the inputs sampled at edge t. packet_data_valid <= data_island_period.
- When data_island_period=0, packet_data <= 0 and all ECC registers <= 0.
- ECC step: next(e,b) = (e>>1) ^ ((e[0]^b) ? ECC_POLY : 0).
  - On every counter==0 cycle the prior ECC value is treated as 0. Each packet's parity is independent and there is no carry across packet boundaries.
- Header, channel 0, bit 0:
  - c<24: output header[c]; ecc_h <= next(ecc_h, header[c]).
  - c>=24: output ecc_h[c-24]; ecc_h holds.
- Subpacket i in 0..3:
  - c<28: even bit sub[i][2c] goes to packet_data[1+i], odd bit sub[i][2c+1] goes to packet_data[5+i]. ecc_i <= next(next(ecc_i, sub[i][2c]), sub[i][2c+1]).
  - c>=28: output ecc_i[2(c-28)] and ecc_i[2(c-28)+1]; ecc_i holds.
- If data_island_period drops mid-packet (c != 31), the counter returns to 0 next cycle and the truncated packet is discarded. No error flag is raised.
- Back-to-back packets: c=31 is followed by c=0 with no bubble. Parity bytes for the packet finishing at c=31 are fully output before any ECC register is reinitialised.

Decomposition:
- Package hdmi_packet_pkg holds:
  - PACKET_PIXELS=32, HEADER_BITS=24, SUB_BITS=56.
  - ECC_POLY default.
  - Pure function bch_next(ecc, bit).
  - typedef subpacket_t (logic [55:0]).
- One natural sub-module: hdmi_bch_lane. It holds one ECC register, has a 1- or 2-bit-per-cycle mode, and handles data/parity muxing. It is instanced five times: header x1, subpackets x4.

Test Plan:
- Reset: hold reset with data_island_period=1 for 3 cycles -> counter=0, packet_enable=0, packet_data=0, packet_data_valid=0.
- Null packet: header=0, subs=0, 64-cycle island -> packet_data=9'h000 on all 64 valid cycles; packet_enable high at c=31 both times.
- Header parity: header=24'h000001, subs=0 -> cycle 0 packet_data=9'h001; cycles 1-23 data bit0=0; cycles 24-31 bit0 serialize 8'h4A LSB-first (0,1,0,1,0,0,1,0).
- Subpacket mapping: sub[2]=56'h3, others 0 -> cycle 0 packet_data[3]=1 and packet_data[7]=1. Cycles 28-31 bits [3]/[7] match a golden bch_next model; lanes 0, 1 and 3 stay 0.
- Abort and back-to-back: drop data_island_period at c=17 -> counter=0 next cycle and valid=0. A fresh 32-cycle island then yields parity identical to the standalone case (no ECC carryover).
- Random: 200 random header/sub packets back-to-back -> bit-exact match against a reference model, including parity at c=24..31 (header) and c=28..31 (subpackets).

Source files
------------

// File: rtl/hdmi_packet_pkg.sv
// Shared constants, types and the BCH parity step for the HDMI data-island packet assembler.
package hdmi_packet_pkg;

    localparam int         PACKET_PIXELS = 32;
    localparam int         HEADER_BITS   = 24;
    localparam int         SUB_BITS      = 56;
    localparam logic [7:0] ECC_POLY      = 8'h83;

    typedef logic [SUB_BITS-1:0] subpacket_t;

    // One LSB-first step of the reflected BCH parity generator.
    function automatic logic [7:0] bch_next(input logic [7:0] ecc,
                                            input logic       data_bit,
                                            input logic [7:0] poly = ECC_POLY);
        return (ecc >> 1) ^ (((ecc[0] ^ data_bit) == 1'b1) ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/hdmi_bch_lane.sv
// One serialisation lane: streams a payload 1 or 2 bits per pixel while accumulating
// its BCH parity, then streams the 8 parity bits in the remaining packet pixels.
module hdmi_bch_lane
    import hdmi_packet_pkg::*;
#(
    parameter int         WIDTH          = SUB_BITS,
    parameter int         BITS_PER_CYCLE = 2,
    parameter logic [7:0] POLY           = ECC_POLY
) (
    input  logic                      clk_pixel,
    input  logic                      reset,
    input  logic                      active,
    input  logic [4:0]                counter,
    input  logic [WIDTH-1:0]          data,
    output logic [BITS_PER_CYCLE-1:0] lane_data
);

    localparam int         DATA_CYCLES  = WIDTH / BITS_PER_CYCLE;
    localparam logic [4:0] FIRST_PARITY = 5'(DATA_CYCLES);

    logic [7:0]                ecc_q;
    logic [7:0]                ecc_d;
    logic [7:0]                ecc_seed;
    logic [2:0]                parity_pos;
    logic [WIDTH-1:0]          data_shifted;
    logic [7:0]                parity_shifted;
    logic [BITS_PER_CYCLE-1:0] lane_d;

    // Select payload or parity bits for this pixel and compute the next parity value.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        ecc_seed       = (counter == 5'd0) ? 8'h00 : ecc_q;
        parity_pos     = 3'(counter - FIRST_PARITY);
        data_shifted   = data >> (BITS_PER_CYCLE * int'(counter));
        parity_shifted = ecc_q >> (BITS_PER_CYCLE * int'(parity_pos));
        ecc_d          = ecc_seed;
        lane_d         = parity_shifted[BITS_PER_CYCLE-1:0];
        if (counter < FIRST_PARITY) begin
            lane_d = data_shifted[BITS_PER_CYCLE-1:0];
            ecc_d  = bch_next(ecc_seed, data_shifted[0], POLY);
            if (BITS_PER_CYCLE == 2) begin
                ecc_d = bch_next(ecc_d, data_shifted[BITS_PER_CYCLE-1], POLY);
            end
        end
    end

    // Parity and output registers; cleared outside data islands so packets never share parity.
    always_ff @(posedge clk_pixel) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset || !active) begin
            ecc_q     <= 8'h00;
            lane_data <= '0;
        end else begin
            ecc_q     <= ecc_d;
            lane_data <= lane_d;
        end
    end

endmodule

// File: rtl/hdmi_packet_assembler.sv
// Data-island packet assembler: paces the packet picker and serialises header and
// subpackets, with BCH parity inserted, into 9-bit symbol payloads for TERC4 encoding.
module hdmi_packet_assembler #(
    parameter logic [7:0] ECC_POLY = hdmi_packet_pkg::ECC_POLY
) (
    input  logic                             clk_pixel,
    input  logic                             reset,
    input  logic                             data_island_period,
    input  logic [23:0]                      header,
    input  hdmi_packet_pkg::subpacket_t [3:0] sub,
    output logic [4:0]                       packet_pixel_counter,
    output logic                             packet_enable,
    output logic [8:0]                       packet_data,
    output logic                             packet_data_valid
);

    import hdmi_packet_pkg::*;

    localparam logic [4:0] LAST_PIXEL = 5'(PACKET_PIXELS - 1);

    logic [0:0] header_bit;
    logic [1:0] sub_bits [4];

    // Position within the packet; free-runs with natural 5-bit wrap during an island.
    always_ff @(posedge clk_pixel) begin
        if (reset || !data_island_period) begin
            packet_pixel_counter <= 5'd0;
        end else begin
            packet_pixel_counter <= packet_pixel_counter + 5'd1;
        end
    end

    // Valid flag tracks the island one pixel late, matching the lane registers.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            packet_data_valid <= 1'b0;
        end else begin
            packet_data_valid <= data_island_period;
        end
    end

    assign packet_enable = data_island_period && (packet_pixel_counter == LAST_PIXEL);

    hdmi_bch_lane #(
        .WIDTH          (HEADER_BITS),
        .BITS_PER_CYCLE (1),
        .POLY           (ECC_POLY)
    ) u_header_lane (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .active    (data_island_period),
        .counter   (packet_pixel_counter),
        .data      (header),
        .lane_data (header_bit)
    );

    for (genvar i = 0; i < 4; i++) begin : g_sub_lane
        hdmi_bch_lane #(
            .WIDTH          (SUB_BITS),
            .BITS_PER_CYCLE (2),
            .POLY           (ECC_POLY)
        ) u_sub_lane (
            .clk_pixel (clk_pixel),
            .reset     (reset),
            .active    (data_island_period),
            .counter   (packet_pixel_counter),
            .data      (sub[i]),
            .lane_data (sub_bits[i])
        );
    end

    // Pack the lane outputs as {odd bits sub3..0, even bits sub3..0, header bit}.
    always_comb begin
        packet_data = {sub_bits[3][1], sub_bits[2][1], sub_bits[1][1], sub_bits[0][1],
                       sub_bits[3][0], sub_bits[2][0], sub_bits[1][0], sub_bits[0][0],
                       header_bit};
    end

endmodule
